// File: rtl/ascon_axis_tx.sv
// ascon_axis_tx: output stage of the Ascon AXI4-Stream wrapper.
// Result words from the core (CT/PT blocks, 2-beat tag, digest words) are
// framed with tkeep/tlast/tuser and queued in a FIFO_DEPTH-entry FIFO that
// decouples the core from m_axis backpressure.
// Optional feature macro: ASCON_TX_PERF_CNT_EN adds saturating perf_beats /
// perf_stalls counters and their ports.
module ascon_axis_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [63:0]  blk_data,
  input  logic [3:0]   blk_nbytes,
  input  logic [3:0]   blk_type,
  input  logic         blk_last,
  input  logic         tag_valid,
  output logic         tag_ready,
  input  logic [127:0] tag_data,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [63:0]  m_axis_tdata,
  output logic [7:0]   m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic [3:0]   m_axis_tuser,
`ifdef ASCON_TX_PERF_CNT_EN
  output logic [CNT_W-1:0] perf_beats,
  output logic [CNT_W-1:0] perf_stalls,
`endif
  output logic         err_sticky
);

  localparam logic [3:0] TUSER_PT     = 4'd4;
  localparam logic [3:0] TUSER_CT     = 4'd5;
  localparam logic [3:0] TUSER_TAG    = 4'd6;
  localparam logic [3:0] TUSER_DIGEST = 4'd9;

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  // Elaboration-time sanity check of the configuration
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (CNT_W < 1)) begin : g_bad_cfg
    $error("ascon_axis_tx: FIFO_DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {S_DATA = 2'd0, S_TAG_WAIT = 2'd1, S_TAG1 = 2'd2} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  user;
  } beat_t;

  state_t              state_q, state_d;
  logic [63:0]         tag_hi_q, tag_hi_d;
  logic                blk_ready_q, blk_ready_d;
  logic                tag_ready_q, tag_ready_d;
  logic                err_q, err_set_s;
  beat_t               mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]   count_q, count_d;
  logic                push_s, pop_s, blk_fire_s, tag_fire_s, is_aead_s, len_ok_s;
  beat_t               push_beat_s;
  logic [8:0]          keep9_s;

  // Classify the incoming word/tag, pick the beat to push and the next state
  always_comb begin
    push_s      = 1'b0;
    push_beat_s = '0;
    state_d     = state_q;
    tag_hi_d    = tag_hi_q;
    err_set_s   = 1'b0;
    blk_fire_s  = blk_valid && blk_ready_q;
    tag_fire_s  = tag_valid && tag_ready_q;
    is_aead_s   = (blk_type == TUSER_CT) || (blk_type == TUSER_PT);
    len_ok_s    = (blk_nbytes != 4'd0) && (blk_nbytes <= 4'd8);
    keep9_s     = (9'd1 << blk_nbytes) - 9'd1;
    case (state_q)
      S_DATA: begin
        if (blk_fire_s) begin
          if (is_aead_s && len_ok_s) begin
            push_s      = 1'b1;
            push_beat_s = '{data: blk_data, keep: keep9_s[7:0], last: 1'b0, user: blk_type};
            state_d     = blk_last ? S_TAG_WAIT : S_DATA;
          end else if (is_aead_s && (blk_nbytes == 4'd0) && blk_last) begin
            // empty message: nothing to emit, go straight to the tag
            state_d = S_TAG_WAIT;
          end else if ((blk_type == TUSER_DIGEST) && len_ok_s) begin
            push_s      = 1'b1;
            push_beat_s = '{data: blk_data, keep: keep9_s[7:0], last: blk_last, user: blk_type};
          end else begin
            err_set_s = 1'b1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_TAG_WAIT: begin
        if (tag_fire_s) begin
          push_s      = 1'b1;
          push_beat_s = '{data: tag_data[63:0], keep: 8'hFF, last: 1'b0, user: TUSER_TAG};
          tag_hi_d    = tag_data[127:64];
          state_d     = S_TAG1;
        end else begin
          state_d = S_TAG_WAIT;
        end
      end
      S_TAG1: begin
        // space for this beat was reserved when the tag was accepted
        push_s      = 1'b1;
        push_beat_s = '{data: tag_hi_q, keep: 8'hFF, last: 1'b1, user: TUSER_TAG};
        state_d     = S_DATA;
      end
      default: begin
        state_d = S_DATA;
      end
    endcase
  end

  // Occupancy bookkeeping and the registered ready terms derived from it
  always_comb begin
    pop_s = (count_q != '0) && m_axis_tready;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
    blk_ready_d = (state_d == S_DATA) && (count_d < FCNT_W'(FIFO_DEPTH));
    tag_ready_d = (state_d == S_TAG_WAIT) && (count_d <= FCNT_W'(FIFO_DEPTH - 2));
  end

  // Framing FSM with registered ready outputs and the sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_DATA;
      tag_hi_q    <= '0;
      blk_ready_q <= 1'b0;
      tag_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_hi_q    <= tag_hi_d;
      blk_ready_q <= blk_ready_d;
      tag_ready_q <= tag_ready_d;
      err_q       <= err_q | err_set_s;
    end
  end

  // Output FIFO storage and pointers; head entry drives m_axis directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_beat_s;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = mem_q[rd_ptr_q].data;
  assign m_axis_tkeep  = mem_q[rd_ptr_q].keep;
  assign m_axis_tlast  = mem_q[rd_ptr_q].last;
  assign m_axis_tuser  = mem_q[rd_ptr_q].user;
  assign blk_ready     = blk_ready_q;
  assign tag_ready     = tag_ready_q;
  assign err_sticky    = err_q;

`ifdef ASCON_TX_PERF_CNT_EN
  logic [CNT_W-1:0] beats_q, stalls_q;

  // Saturating counters of delivered beats and backpressured cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (pop_s && (beats_q != '1)) begin
        beats_q <= beats_q + CNT_W'(1);
      end
      if (m_axis_tvalid && !m_axis_tready && (stalls_q != '1)) begin
        stalls_q <= stalls_q + CNT_W'(1);
      end
    end
  end

  assign perf_beats  = beats_q;
  assign perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_ascon_axis_tx.sv
// Directed self-checking bench for ascon_axis_tx.
module tb_ascon_axis_tx;

  localparam logic [3:0] T_KEY = 4'd1, T_PT = 4'd4, T_CT = 4'd5, T_TAG = 4'd6, T_DIG = 4'd9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         blk_valid = 1'b0, blk_ready, blk_last = 1'b0;
  logic [63:0]  blk_data = '0;
  logic [3:0]   blk_nbytes = '0, blk_type = '0;
  logic         tag_valid = 1'b0, tag_ready;
  logic [127:0] tag_data = '0;
  logic         m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic [3:0]   m_axis_tuser;
  logic         err_sticky;
`ifdef ASCON_TX_PERF_CNT_EN
  logic [31:0]  perf_beats, perf_stalls;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] cap_data [$];
  logic [7:0]  cap_keep [$];
  logic        cap_last [$];
  logic [3:0]  cap_user [$];

  always #5 clk = ~clk;

  ascon_axis_tx #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_nbytes(blk_nbytes), .blk_type(blk_type), .blk_last(blk_last),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_data(tag_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
`ifdef ASCON_TX_PERF_CNT_EN
    .perf_beats(perf_beats), .perf_stalls(perf_stalls),
`endif
    .err_sticky(err_sticky)
  );

  // Record every beat that will be popped at the following rising edge
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      cap_data.push_back(m_axis_tdata);
      cap_keep.push_back(m_axis_tkeep);
      cap_last.push_back(m_axis_tlast);
      cap_user.push_back(m_axis_tuser);
    end
  end

  task automatic clear_cap();
    cap_data.delete(); cap_keep.delete(); cap_last.delete(); cap_user.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one word and hold it until accepted; returns at accept edge + 1
  task automatic send_blk(input logic [63:0] d, input logic [3:0] nb, input logic [3:0] ty, input logic lst);
    bit ok = 1'b0;
    blk_data = d; blk_nbytes = nb; blk_type = ty; blk_last = lst; blk_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (blk_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    blk_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL blk_handshake: blk_ready stayed 0, required 1 within 100 cycles");
    end
  endtask

  task automatic send_tag(input logic [127:0] t);
    bit ok = 1'b0;
    tag_data = t; tag_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (tag_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    tag_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL tag_handshake: tag_ready stayed 0, required 1 within 100 cycles");
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, blk_ready, tag_ready, err_sticky} !== 81'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: tvalid=%b tdata=%h tkeep=%h tlast=%b tuser=%h blk_ready=%b tag_ready=%b err=%b, required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, blk_ready, tag_ready, err_sticky);
    end
`ifdef ASCON_TX_PERF_CNT_EN
    n_cmp++;
    if ({perf_beats, perf_stalls} !== 64'd0) begin
      n_bad++; $display("FAIL reset_perf: beats=%0d stalls=%0d, required 0 0", perf_beats, perf_stalls);
    end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({blk_ready, tag_ready} !== 2'b10) begin
      n_bad++; $display("FAIL post_reset_ready: blk_ready=%b tag_ready=%b, required 1 0", blk_ready, tag_ready);
    end
  endtask

  task automatic test_hash();
    logic [63:0] w [4] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                           64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};
    clear_cap();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_blk(w[i], 4'd8, T_DIG, (i == 3));
    n_cmp++;
    if (blk_ready !== 1'b0) begin
      n_bad++; $display("FAIL hash_full_ready: blk_ready=%b, required 0", blk_ready);
    end
    for (int c = 0; c < 7; c++) begin
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== {1'b1, w[0], 8'hFF, 1'b0, T_DIG}) begin
        n_bad++;
        $display("FAIL hash_stall_stable: tvalid=%b tdata=%h tkeep=%h tlast=%b tuser=%h, required 1 %h ff 0 9",
                 m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, w[0]);
      end
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b1;
    idle(8);
    n_cmp++;
    if (cap_data.size() !== 4) begin
      n_bad++; $display("FAIL hash_beat_count: got %0d, required 4", cap_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (cap_data.size() > i) begin
        n_cmp++;
        if ({cap_data[i], cap_keep[i], cap_last[i], cap_user[i]} !== {w[i], 8'hFF, (i == 3), T_DIG}) begin
          n_bad++;
          $display("FAIL hash_beat%0d: data=%h keep=%h last=%b user=%h, required %h ff %b 9",
                   i, cap_data[i], cap_keep[i], cap_last[i], cap_user[i], w[i], (i == 3));
        end
      end
    end
`ifdef ASCON_TX_PERF_CNT_EN
    n_cmp++;
    if ({perf_beats, perf_stalls} !== {32'd4, 32'd10}) begin
      n_bad++; $display("FAIL hash_perf: beats=%0d stalls=%0d, required 4 10", perf_beats, perf_stalls);
    end
`endif
  endtask

  task automatic test_enc();
    logic [63:0] ed [4] = '{64'h0123_4567_89AB_CDEF, 64'hAAAA_BBBB_1122_3344,
                            64'h0706_0504_0302_0100, 64'h0F0E_0D0C_0B0A_0908};
    logic [7:0]  ek [4] = '{8'hFF, 8'h0F, 8'hFF, 8'hFF};
    logic [3:0]  eu [4] = '{T_CT, T_CT, T_TAG, T_TAG};
    clear_cap();
    m_axis_tready = 1'b1;
    send_blk(ed[0], 4'd8, T_CT, 1'b0);
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, ed[0]}) begin
      n_bad++; $display("FAIL enc_latency: tvalid=%b tdata=%h, required 1 %h", m_axis_tvalid, m_axis_tdata, ed[0]);
    end
    send_blk(ed[1], 4'd4, T_CT, 1'b1);
    send_tag(128'h0F0E0D0C0B0A0908_0706050403020100);
    idle(6);
    n_cmp++;
    if (cap_data.size() !== 4) begin
      n_bad++; $display("FAIL enc_beat_count: got %0d, required 4", cap_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (cap_data.size() > i) begin
        n_cmp++;
        if ({cap_data[i], cap_keep[i], cap_last[i], cap_user[i]} !== {ed[i], ek[i], (i == 3), eu[i]}) begin
          n_bad++;
          $display("FAIL enc_beat%0d: data=%h keep=%h last=%b user=%h, required %h %h %b %h",
                   i, cap_data[i], cap_keep[i], cap_last[i], cap_user[i], ed[i], ek[i], (i == 3), eu[i]);
        end
      end
    end
  endtask

  task automatic test_empty_pt();
    logic [127:0] t = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
    clear_cap();
    send_blk(64'h0, 4'd0, T_PT, 1'b1);
    send_tag(t);
    idle(6);
    n_cmp++;
    if (cap_data.size() !== 2) begin
      n_bad++; $display("FAIL empty_beat_count: got %0d, required 2", cap_data.size());
    end
    if (cap_data.size() == 2) begin
      n_cmp++;
      if ({cap_data[0], cap_last[0], cap_user[0], cap_data[1], cap_last[1], cap_user[1]} !==
          {t[63:0], 1'b0, T_TAG, t[127:64], 1'b1, T_TAG}) begin
        n_bad++;
        $display("FAIL empty_beats: %h/%b/%h %h/%b/%h, required %h/0/6 %h/1/6",
                 cap_data[0], cap_last[0], cap_user[0], cap_data[1], cap_last[1], cap_user[1], t[63:0], t[127:64]);
      end
    end
    n_cmp++;
    if (err_sticky !== 1'b0) begin
      n_bad++; $display("FAIL empty_err: err_sticky=%b, required 0", err_sticky);
    end
  endtask

  task automatic test_illegal();
    clear_cap();
    send_blk(64'h1234, 4'd8, T_KEY, 1'b0);
    n_cmp++;
    if (err_sticky !== 1'b1) begin
      n_bad++; $display("FAIL illegal_key_err: err_sticky=%b, required 1", err_sticky);
    end
    send_blk(64'h5678, 4'd9, T_DIG, 1'b0);
    idle(4);
    n_cmp++;
    if ((cap_data.size() !== 0) || (m_axis_tvalid !== 1'b0)) begin
      n_bad++; $display("FAIL illegal_dropped: beats=%0d tvalid=%b, required 0 0", cap_data.size(), m_axis_tvalid);
    end
    send_blk(64'hFFEE_DDCC_BBAA_9988, 4'd3, T_DIG, 1'b1);
    idle(3);
    n_cmp++;
    if ((cap_data.size() !== 1) || ({cap_data[0], cap_keep[0], cap_last[0], cap_user[0]} !==
        {64'hFFEE_DDCC_BBAA_9988, 8'h07, 1'b1, T_DIG})) begin
      n_bad++; $display("FAIL illegal_recover: beats=%0d, required 1 beat ffeeddccbbaa9988/07/1/9", cap_data.size());
    end
    n_cmp++;
    if (err_sticky !== 1'b1) begin
      n_bad++; $display("FAIL illegal_sticky: err_sticky=%b, required 1", err_sticky);
    end
  endtask

  task automatic test_reset_mid();
    clear_cap();
    m_axis_tready = 1'b0;
    send_blk(64'hA1, 4'd8, T_CT, 1'b0);
    send_blk(64'hA2, 4'd8, T_CT, 1'b1);
    send_tag(128'h1);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_axis_tvalid, blk_ready, tag_ready} !== 3'b000) begin
      n_bad++; $display("FAIL midreset_async: tvalid=%b blk_ready=%b tag_ready=%b, required 0 0 0",
                        m_axis_tvalid, blk_ready, tag_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    idle(5);
    n_cmp++;
    if ((cap_data.size() !== 0) || ({m_axis_tvalid, tag_ready, blk_ready, err_sticky} !== 4'b0010)) begin
      n_bad++; $display("FAIL midreset_after: beats=%0d tvalid=%b tag_ready=%b blk_ready=%b err=%b, required 0 0 0 1 0",
                        cap_data.size(), m_axis_tvalid, tag_ready, blk_ready, err_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_hash();
    test_enc();
    test_empty_pt();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
